// File: rtl/mma_sched_pkg.sv
// Shared types for the tiled-GEMM scheduler: FSM state encoding, tile index type, accumulator width helper.
package mma_sched_pkg;

  // Inner tile dimension of the MMA core; it does not change how beats are scheduled.
  localparam int MMA_K = 4;
  localparam int TILE_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_e;

  typedef logic [TILE_W_DEF-1:0] tile_idx_t;

  function automatic int acc_w(input int p);
    return 4 * p;
  endfunction

endpackage

// File: rtl/mma_sched_tile_counter.sv
// Nested ki/ni/mi tile walker; latches the tile counts when cleared at job start.
module mma_sched_tile_counter #(
  parameter int TILE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear,
  input  logic              inc_k,
  input  logic              inc_tile,
  input  logic [TILE_W-1:0] cfg_m_i,
  input  logic [TILE_W-1:0] cfg_n_i,
  input  logic [TILE_W-1:0] cfg_k_i,
  output logic [TILE_W-1:0] mi_o,
  output logic [TILE_W-1:0] ni_o,
  output logic [TILE_W-1:0] ki_o,
  output logic              last_k,
  output logic              last_tile
);

  localparam logic [TILE_W-1:0] IDX_ONE = TILE_W'(1);

  logic [TILE_W-1:0] m_q, n_q, k_q, m_d, n_d, k_d;
  logic [TILE_W-1:0] mi_q, ni_q, ki_q, mi_d, ni_d, ki_d;

  always_comb begin
    m_d  = m_q;
    n_d  = n_q;
    k_d  = k_q;
    mi_d = mi_q;
    ni_d = ni_q;
    ki_d = ki_q;
    if (clear) begin
      m_d  = cfg_m_i;
      n_d  = cfg_n_i;
      k_d  = cfg_k_i;
      mi_d = '0;
      ni_d = '0;
      ki_d = '0;
    end else if (inc_k) begin
      ki_d = ki_q + IDX_ONE;
    end else if (inc_tile) begin
      ki_d = '0;
      if (ni_q == n_q - IDX_ONE) begin
        ni_d = '0;
        mi_d = mi_q + IDX_ONE;
      end else begin
        ni_d = ni_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m_q  <= '0;
      n_q  <= '0;
      k_q  <= '0;
      mi_q <= '0;
      ni_q <= '0;
      ki_q <= '0;
    end else begin
      m_q  <= m_d;
      n_q  <= n_d;
      k_q  <= k_d;
      mi_q <= mi_d;
      ni_q <= ni_d;
      ki_q <= ki_d;
    end
  end

  assign mi_o      = mi_q;
  assign ni_o      = ni_q;
  assign ki_o      = ki_q;
  assign last_k    = (ki_q == k_q - IDX_ONE);
  assign last_tile = (mi_q == m_q - IDX_ONE) && (ni_q == n_q - IDX_ONE);

endmodule

// File: rtl/mma_tile_scheduler.sv
// Sequences tiled GEMM beats over one MMA core, feeding the running D back as C.
// Optional MMA_SCHED_PERF_EN adds busy/stall/beat performance counters.
module mma_tile_scheduler
  import mma_sched_pkg::*;
#(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int P      = 8,
  parameter int TILE_W = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [TILE_W-1:0]           cfg_m_tiles_i,
  input  logic [TILE_W-1:0]           cfg_n_tiles_i,
  input  logic [TILE_W-1:0]           cfg_k_tiles_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [TILE_W-1:0]           op_mi_o,
  output logic [TILE_W-1:0]           op_ni_o,
  output logic [TILE_W-1:0]           op_ki_o,
  input  logic                        op_valid_i,
  output logic                        op_ready_o,
  output logic                        mma_valid_o,
  input  logic                        mma_ready_i,
  output logic [M*N*acc_w(P)-1:0]     mma_c_o,
  input  logic                        mma_valid_i,
  output logic                        mma_ready_o,
  input  logic [M*N*acc_w(P)-1:0]     mma_d_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [M*N*acc_w(P)-1:0]     res_d_o,
  output logic [TILE_W-1:0]           res_mi_o,
  output logic [TILE_W-1:0]           res_ni_o
`ifdef MMA_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_busy_o,
  output logic [31:0]                 perf_stall_o,
  output logic [31:0]                 perf_beats_o
`endif
);

  localparam int TILE_BITS = M * N * acc_w(P);

  state_e                 state_q, state_d;
  logic [TILE_BITS-1:0]   acc_q, acc_d;
  logic                   done_q, done_d;
  logic                   clear, inc_k, inc_tile, last_k, last_tile, cfg_zero;
  logic [TILE_W-1:0]      mi, ni, ki;

  mma_sched_tile_counter #(.TILE_W(TILE_W)) u_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (clear),
    .inc_k     (inc_k),
    .inc_tile  (inc_tile),
    .cfg_m_i   (cfg_m_tiles_i),
    .cfg_n_i   (cfg_n_tiles_i),
    .cfg_k_i   (cfg_k_tiles_i),
    .mi_o      (mi),
    .ni_o      (ni),
    .ki_o      (ki),
    .last_k    (last_k),
    .last_tile (last_tile)
  );

  assign cfg_zero = (cfg_m_tiles_i == '0) || (cfg_n_tiles_i == '0) || (cfg_k_tiles_i == '0);

  // Only one beat is ever in flight: the next C depends on the D just returned.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    done_d   = (state_q == S_FIN);
    clear    = 1'b0;
    inc_k    = 1'b0;
    inc_tile = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          clear   = 1'b1;
          state_d = cfg_zero ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_valid_i && mma_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mma_valid_i) begin
          acc_d = mma_d_i;
          if (last_k) begin
            state_d = S_OUT;
          end else begin
            inc_k   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_OUT: begin
        if (res_ready_i) begin
          if (last_tile) begin
            state_d = S_FIN;
          end else begin
            inc_tile = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign op_mi_o     = mi;
  assign op_ni_o     = ni;
  assign op_ki_o     = ki;
  assign mma_valid_o = (state_q == S_ISSUE) && op_valid_i;
  assign op_ready_o  = (state_q == S_ISSUE) && mma_ready_i;
  assign mma_c_o     = (ki == '0) ? '0 : acc_q;
  assign mma_ready_o = (state_q == S_WAIT);
  assign res_valid_o = (state_q == S_OUT);
  assign res_d_o     = acc_q;
  assign res_mi_o    = mi;
  assign res_ni_o    = ni;

`ifdef MMA_SCHED_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d, perf_beats_q, perf_beats_d;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    perf_beats_d = perf_beats_q;
    if (clear) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
      perf_beats_d = '0;
    end else begin
      if (state_q != S_IDLE) perf_busy_d = perf_busy_q + 32'd1;
      if (state_q == S_ISSUE && !op_valid_i) perf_stall_d = perf_stall_q + 32'd1;
      if (state_q == S_ISSUE && op_valid_i && mma_ready_i) perf_beats_d = perf_beats_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
      perf_beats_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
      perf_beats_q <= perf_beats_d;
    end
  end

  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;
  assign perf_beats_o = perf_beats_q;
`endif

endmodule

// File: tb/tb_mma_tile_scheduler.sv
// Scoreboard bench: stimulus queues expected C operands and result tiles; an MMA model and a result monitor check them.
`timescale 1ns/1ps
module tb_mma_tile_scheduler;
  import mma_sched_pkg::*;

  localparam int M = 4, N = 4, P = 8, TW = 8, KD = 4;
  localparam int ACC_W = 32;
  localparam int TB = M * N * ACC_W;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0;
  logic [TW-1:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic busy_o, done_o, op_ready_o, mma_valid_o, mma_ready_o, res_valid_o;
  logic [TW-1:0] op_mi_o, op_ni_o, op_ki_o, res_mi_o, res_ni_o;
  logic op_valid_i = 1'b0;
  logic mma_ready_i = 1'b1;
  logic mma_valid_i = 1'b0;
  logic res_ready_i = 1'b1;
  logic [TB-1:0] mma_c_o, res_d_o;
  logic [TB-1:0] mma_d_i = '0;

  mma_tile_scheduler #(.M(M), .N(N), .P(P), .TILE_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .cfg_m_tiles_i(cfg_m), .cfg_n_tiles_i(cfg_n), .cfg_k_tiles_i(cfg_k),
    .busy_o(busy_o), .done_o(done_o),
    .op_mi_o(op_mi_o), .op_ni_o(op_ni_o), .op_ki_o(op_ki_o),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .mma_valid_o(mma_valid_o), .mma_ready_i(mma_ready_i), .mma_c_o(mma_c_o),
    .mma_valid_i(mma_valid_i), .mma_ready_o(mma_ready_o), .mma_d_i(mma_d_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_d_o(res_d_o),
    .res_mi_o(res_mi_o), .res_ni_o(res_ni_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    tile_idx_t mi;
    tile_idx_t ni;
    int        val;
  } res_t;

  int   n_cmp = 0, n_bad = 0, n_beats = 0, cyc = 0;
  int   exp_c[$];
  res_t exp_res[$];
  int   a_m[M][KD], b_m[KD][N];
  logic stall_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tile(input string name, input logic [TB-1:0] t, input int val);
    logic [63:0] act;
    act = 64'(val);
    for (int i = M * N - 1; i >= 0; i--)
      if (t[i*ACC_W +: ACC_W] !== ACC_W'(val)) act = {32'd0, t[i*ACC_W +: ACC_W]};
    check(name, act, 64'(val));
  endtask

  task automatic set_ab(input bit a_ones, input int bval);
    for (int r = 0; r < M; r++)
      for (int k = 0; k < KD; k++) a_m[r][k] = a_ones ? 1 : ((r == k) ? 1 : 0);
    for (int k = 0; k < KD; k++)
      for (int c = 0; c < N; c++) b_m[k][c] = bval;
  endtask

  task automatic start_job(input int m, input int n, input int k);
    @(posedge clk); #1;
    cfg_m = TW'(m); cfg_n = TW'(n); cfg_k = TW'(k);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (t < 3000) begin
      @(negedge clk);
      if (done_o) break;
      t++;
    end
    check(name, 64'(t < 3000), 64'd1);
  endtask

  task automatic zero_job(input int m, input int n, input int k);
    int b0;
    b0 = n_beats;
    start_job(m, n, k);
    @(negedge clk);
    check("zero_done_early", 64'(done_o), 64'd0);
    check("zero_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    check("zero_done_pulse", 64'(done_o), 64'd1);
    check("zero_beats", 64'(n_beats - b0), 64'd0);
  endtask

  // Operand fetch: always has data unless stalling every other cycle
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      op_valid_i = !(stall_en && cyc[0]);
    end
  end

  // MMA core model: D = A*B + C after a fixed latency
  initial begin : mma_model
    logic [TB-1:0] d;
    int cv, s;
    forever begin
      @(negedge clk);
      if (mma_valid_o && mma_ready_i) begin
        n_beats++;
        if (exp_c.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL beat_c: unexpected beat ki=%0d", op_ki_o);
        end else begin
          cv = exp_c.pop_front();
          check_tile("beat_c", mma_c_o, cv);
        end
        for (int r = 0; r < M; r++)
          for (int c = 0; c < N; c++) begin
            s = int'(mma_c_o[(r*N+c)*ACC_W +: ACC_W]);
            for (int k = 0; k < KD; k++) s += a_m[r][k] * b_m[k][c];
            d[(r*N+c)*ACC_W +: ACC_W] = ACC_W'(s);
          end
        repeat (LAT + 1) @(posedge clk);
        #1;
        mma_valid_i = 1'b1;
        mma_d_i = d;
        @(posedge clk); #1;
        mma_valid_i = 1'b0;
      end
    end
  end

  initial begin : res_mon
    res_t e;
    forever begin
      @(negedge clk);
      if (res_valid_o && res_ready_i) begin
        if (exp_res.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL res: unexpected result mi=%0d ni=%0d", res_mi_o, res_ni_o);
        end else begin
          e = exp_res.pop_front();
          check("res_mi", 64'(res_mi_o), 64'(e.mi));
          check("res_ni", 64'(res_ni_o), 64'(e.ni));
          check_tile("res_d", res_d_o, e.val);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b0, t;
    logic [TB-1:0] held;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_op_ready", 64'(op_ready_o), 64'd0);
    check("rst_mma_valid", 64'(mma_valid_o), 64'd0);
    check("rst_mma_ready", 64'(mma_ready_o), 64'd0);
    check("rst_res_valid", 64'(res_valid_o), 64'd0);
    check("rst_idx", 64'({op_mi_o, op_ni_o, op_ki_o}), 64'd0);
    check_tile("rst_acc", res_d_o, 0);

    // Single tile, single beat
    set_ab(1'b0, 2);
    exp_c.push_back(0);
    exp_res.push_back('{mi: 8'd0, ni: 8'd0, val: 2});
    b0 = n_beats;
    start_job(1, 1, 1);
    wait_done("t1_done");
    check("t1_beats", 64'(n_beats - b0), 64'd1);
    @(negedge clk);
    check("t1_done_one_cycle", 64'(done_o), 64'd0);
    check("t1_idle", 64'(busy_o), 64'd0);

    // Accumulation across three k beats, with fetch stalls
    set_ab(1'b0, 1);
    stall_en = 1'b1;
    exp_c.push_back(0); exp_c.push_back(1); exp_c.push_back(2);
    exp_res.push_back('{mi: 8'd0, ni: 8'd0, val: 3});
    b0 = n_beats;
    start_job(1, 1, 3);
    wait_done("t2_done");
    check("t2_beats", 64'(n_beats - b0), 64'd3);
    stall_en = 1'b0;

    // 2x3 tile walk, A=B=all ones gives 4 per element
    set_ab(1'b1, 1);
    for (int mi = 0; mi < 2; mi++)
      for (int ni = 0; ni < 3; ni++) begin
        exp_c.push_back(0);
        exp_res.push_back('{mi: tile_idx_t'(mi), ni: tile_idx_t'(ni), val: 4});
      end
    b0 = n_beats;
    start_job(2, 3, 1);
    wait_done("t3_done");
    check("t3_beats", 64'(n_beats - b0), 64'd6);

    // Result back-pressure
    set_ab(1'b0, 3);
    res_ready_i = 1'b0;
    exp_c.push_back(0);
    exp_res.push_back('{mi: 8'd0, ni: 8'd0, val: 3});
    b0 = n_beats;
    start_job(1, 1, 1);
    t = 0;
    while (t < 200 && !res_valid_o) begin
      @(negedge clk);
      t++;
    end
    check("t4_res_seen", 64'(res_valid_o), 64'd1);
    held = res_d_o;
    repeat (10) begin
      @(negedge clk);
      check("t4_hold_d", 64'(res_d_o === held), 64'd1);
      check("t4_hold_valid", 64'(res_valid_o), 64'd1);
      check("t4_op_ready", 64'(op_ready_o), 64'd0);
      check("t4_mma_valid", 64'(mma_valid_o), 64'd0);
    end
    @(posedge clk); #1;
    res_ready_i = 1'b1;
    wait_done("t4_done");
    check("t4_beats", 64'(n_beats - b0), 64'd1);

    // Zero tile counts
    zero_job(1, 1, 0);
    repeat (2) @(posedge clk);
    zero_job(0, 2, 2);
    repeat (2) @(posedge clk);

    // Reset while a beat is in flight
    set_ab(1'b0, 1);
    exp_c.push_back(0); exp_c.push_back(1); exp_c.push_back(2);
    exp_res.push_back('{mi: 8'd0, ni: 8'd0, val: 3});
    start_job(1, 1, 3);
    t = 0;
    while (t < 200 && !mma_ready_o) begin
      @(negedge clk);
      t++;
    end
    check("t6_in_wait", 64'(mma_ready_o), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    check("t6_busy", 64'(busy_o), 64'd0);
    check("t6_done", 64'(done_o), 64'd0);
    check("t6_op_ready", 64'(op_ready_o), 64'd0);
    check("t6_mma_valid", 64'(mma_valid_o), 64'd0);
    check("t6_mma_ready", 64'(mma_ready_o), 64'd0);
    check("t6_res_valid", 64'(res_valid_o), 64'd0);
    check_tile("t6_acc", res_d_o, 0);
    rst_ni = 1'b1;
    exp_c.delete();
    exp_res.delete();
    repeat (8) @(posedge clk);
    set_ab(1'b0, 2);
    exp_c.push_back(0);
    exp_res.push_back('{mi: 8'd0, ni: 8'd0, val: 2});
    b0 = n_beats;
    start_job(1, 1, 1);
    wait_done("t6_rerun_done");
    check("t6_rerun_beats", 64'(n_beats - b0), 64'd1);

    repeat (3) @(negedge clk);
    check("end_exp_c_empty", 64'(exp_c.size()), 64'd0);
    check("end_exp_res_empty", 64'(exp_res.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
